island_scheduler: RTL and testbench

- Sequences HDMI data-island periods inside horizontal and vertical blanking.
- Collects packet requests (audio sample packets, ACR, AVI InfoFrame, Audio InfoFrame) and decides whether an island fits in the current blanking window and how many packets it carries.
- Arbitrates the packet slots by fixed priority and drives per-pixel period and slot controls to the HDMI encoder front end.
- Sits between the timing/audio sources and the packet assembler/TMDS encoder, in the pixel clock domain.

---
 rtl/island_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_island_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/island_scheduler.sv
// island_scheduler: places HDMI data islands inside blanking windows and
// arbitrates their 32-pixel packet slots among ACR, audio and InfoFrame requests.
module island_scheduler #(
  parameter int H_BLANK      = 370,
  parameter int MIN_CTRL     = 12,
  parameter int TAIL_RESERVE = 22,
  parameter int MAX_PACKETS  = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic       line_end,
  input  logic       frame_end,
  input  logic       audio_sample_strobe,
  input  logic       acr_req,
  output logic       island_active,
  output logic       preamble,
  output logic       guard,
  output logic       pkt_start,
  output logic [1:0] pkt_type,
  output logic [2:0] pkt_samples,
  output logic       audio_overflow,
  output logic       collision
);
  localparam int FIT_RAW = (H_BLANK - MIN_CTRL - 12 - TAIL_RESERVE) / 32;
  localparam int FIT     = (FIT_RAW < MAX_PACKETS) ? FIT_RAW : MAX_PACKETS;
  localparam int BCW     = $clog2(MIN_CTRL) + 1;
  localparam logic [BCW-1:0] BC_DECIDE = BCW'(MIN_CTRL - 1);
  localparam logic [BCW-1:0] BC_MAX    = '1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_LGUARD, S_PKT, S_TGUARD} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] blank_cnt_q, blank_cnt_d;
  logic [4:0]     pix_q, pix_d, slot_q, slot_d, n_q, n_d, scnt_q, scnt_d;
  logic           de_prev_q, de_prev_d, saw_de_q, saw_de_d;
  logic           acr_q, acr_d, avi_q, avi_d, aif_q, aif_d;
  logic           island_active_q, island_active_d, preamble_q, preamble_d;
  logic           guard_q, guard_d, pkt_start_q, pkt_start_d;
  logic [1:0]     pkt_type_q, pkt_type_d;
  logic [2:0]     pkt_samples_q, pkt_samples_d;
  logic           audio_overflow_q, audio_overflow_d, collision_q, collision_d;

  logic       de_rise, win_open, in_island, slot_begin;
  logic       serve_acr, serve_avi, serve_aif;
  logic [2:0] take;
  logic [4:0] scnt_sub, n_now;
  logic [5:0] need;

  always_comb begin
    de_rise   = de & ~de_prev_q;
    win_open  = (~de & de_prev_q) | (line_end & ~de & ~saw_de_q);
    in_island = state_q inside {S_PRE, S_LGUARD, S_PKT, S_TGUARD};
    de_prev_d = de;
    saw_de_d  = line_end ? de : (saw_de_q | de);

    if (win_open)                   blank_cnt_d = '0;
    else if (blank_cnt_q == BC_MAX) blank_cnt_d = blank_cnt_q;
    else                            blank_cnt_d = blank_cnt_q + BCW'(1);

    // audio needs one packet per started group of four samples
    need  = 6'(acr_q) + 6'(avi_q) + 6'(aif_q) + ((6'(scnt_q) + 6'd3) >> 2);
    n_now = (need > 6'(FIT)) ? 5'(FIT) : need[4:0];

    state_d     = state_q;
    pix_d       = pix_q + 5'd1;
    slot_d      = slot_q;
    n_d         = n_q;
    slot_begin  = 1'b0;
    collision_d = collision_q;
    case (state_q)
      S_IDLE:   if (win_open) state_d = S_WAIT;
      S_WAIT: begin
        if (de_rise) state_d = S_IDLE;
        else if (!win_open && blank_cnt_q == BC_DECIDE && n_now != 5'd0) begin
          state_d = S_PRE;
          n_d     = n_now;
          pix_d   = 5'd0;
        end
      end
      S_PRE:    if (pix_q == 5'd7) begin state_d = S_LGUARD; pix_d = 5'd0; end
      S_LGUARD: if (pix_q == 5'd1) begin
        state_d    = S_PKT;
        pix_d      = 5'd0;
        slot_d     = 5'd0;
        slot_begin = 1'b1;
      end
      S_PKT:    if (pix_q == 5'd31) begin
        if (slot_q + 5'd1 == n_q) state_d = S_TGUARD;
        else begin
          slot_d     = slot_q + 5'd1;
          slot_begin = 1'b1;
        end
      end
      S_TGUARD: if (pix_q == 5'd1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (in_island && de_rise) begin
      state_d     = S_IDLE;
      slot_begin  = 1'b0;
      collision_d = 1'b1;
    end

    serve_acr     = 1'b0;
    serve_avi     = 1'b0;
    serve_aif     = 1'b0;
    take          = 3'd0;
    pkt_type_d    = pkt_type_q;
    pkt_samples_d = pkt_samples_q;
    if (slot_begin) begin
      pkt_samples_d = 3'd0;
      pkt_type_d    = 2'd0;
      if (acr_q) serve_acr = 1'b1;
      else if (scnt_q != 5'd0) begin
        take          = (scnt_q > 5'd4) ? 3'd4 : scnt_q[2:0];
        pkt_type_d    = 2'd1;
        pkt_samples_d = take;
      end else if (avi_q) begin
        serve_avi  = 1'b1;
        pkt_type_d = 2'd2;
      end else if (aif_q) begin
        serve_aif  = 1'b1;
        pkt_type_d = 2'd3;
      end
    end
    if (state_d != S_PKT) begin
      pkt_type_d    = 2'd0;
      pkt_samples_d = 3'd0;
    end

    acr_d = acr_req | (acr_q & ~serve_acr);
    avi_d = frame_end | (avi_q & ~serve_avi);
    aif_d = frame_end | (aif_q & ~serve_aif);
    scnt_sub         = scnt_q - {2'b00, take};
    audio_overflow_d = audio_overflow_q | (audio_sample_strobe & (scnt_sub == 5'd31));
    scnt_d           = (audio_sample_strobe && scnt_sub != 5'd31) ? scnt_sub + 5'd1 : scnt_sub;

    island_active_d = state_d inside {S_PRE, S_LGUARD, S_PKT, S_TGUARD};
    preamble_d      = (state_d == S_PRE);
    guard_d         = (state_d == S_LGUARD) || (state_d == S_TGUARD);
    pkt_start_d     = slot_begin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      blank_cnt_q      <= '0;
      pix_q            <= '0;
      slot_q           <= '0;
      n_q              <= '0;
      scnt_q           <= '0;
      de_prev_q        <= 1'b0;
      saw_de_q         <= 1'b0;
      acr_q            <= 1'b0;
      avi_q            <= 1'b0;
      aif_q            <= 1'b0;
      island_active_q  <= 1'b0;
      preamble_q       <= 1'b0;
      guard_q          <= 1'b0;
      pkt_start_q      <= 1'b0;
      pkt_type_q       <= '0;
      pkt_samples_q    <= '0;
      audio_overflow_q <= 1'b0;
      collision_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      blank_cnt_q      <= blank_cnt_d;
      pix_q            <= pix_d;
      slot_q           <= slot_d;
      n_q              <= n_d;
      scnt_q           <= scnt_d;
      de_prev_q        <= de_prev_d;
      saw_de_q         <= saw_de_d;
      acr_q            <= acr_d;
      avi_q            <= avi_d;
      aif_q            <= aif_d;
      island_active_q  <= island_active_d;
      preamble_q       <= preamble_d;
      guard_q          <= guard_d;
      pkt_start_q      <= pkt_start_d;
      pkt_type_q       <= pkt_type_d;
      pkt_samples_q    <= pkt_samples_d;
      audio_overflow_q <= audio_overflow_d;
      collision_q      <= collision_d;
    end
  end

  assign island_active  = island_active_q;
  assign preamble       = preamble_q;
  assign guard          = guard_q;
  assign pkt_start      = pkt_start_q;
  assign pkt_type       = pkt_type_q;
  assign pkt_samples    = pkt_samples_q;
  assign audio_overflow = audio_overflow_q;
  assign collision      = collision_q;
endmodule

// File: tb/tb_island_scheduler.sv
// Bench for island_scheduler: scenario tasks compare captured blanking windows
// against a packet-level model of pending requests.
module tb_island_scheduler;
  localparam int FIT  = (370 - 12 - 12 - 22) / 32;
  localparam int MAXW = 400;

  logic clk = 1'b0;
  logic rst, de, line_end, frame_end, audio_sample_strobe, acr_req;
  logic island_active, preamble, guard, pkt_start, audio_overflow, collision;
  logic [1:0] pkt_type;
  logic [2:0] pkt_samples;

  island_scheduler dut (
    .clk(clk), .rst(rst), .de(de), .line_end(line_end), .frame_end(frame_end),
    .audio_sample_strobe(audio_sample_strobe), .acr_req(acr_req),
    .island_active(island_active), .preamble(preamble), .guard(guard),
    .pkt_start(pkt_start), .pkt_type(pkt_type), .pkt_samples(pkt_samples),
    .audio_overflow(audio_overflow), .collision(collision)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [8:0] obs [MAXW];
  logic [8:0] exp_v [MAXW];
  int m_acr, m_scnt, m_avi, m_aif;
  bit m_ovf, m_coll;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] pix_now();
    return {island_active, preamble, guard, pkt_start, pkt_type, pkt_samples};
  endfunction

  task automatic add_samples(input int n);
    for (int i = 0; i < n; i++) begin
      audio_sample_strobe = 1'b1;
      tick();
      if (m_scnt == 31) m_ovf = 1'b1;
      else m_scnt++;
    end
    audio_sample_strobe = 1'b0;
  endtask

  task automatic pulse_acr();
    acr_req = 1'b1; tick(); acr_req = 1'b0; m_acr = 1;
  endtask

  task automatic pulse_frame();
    frame_end = 1'b1; tick(); frame_end = 1'b0; m_avi = 1; m_aif = 1;
  endtask

  task automatic end_line();
    de = 1'b1;
    repeat (20) tick();
  endtask

  // Opens a window (de fall, or vblank line_end) and records each blank pixel;
  // de is raised after pixel abort_at when abort_at >= 0.
  task automatic capture_window(input int len, input int abort_at, input bit vblank);
    if (vblank) line_end = 1'b1;
    else de = 1'b0;
    for (int b = 0; b < len; b++) begin
      tick();
      line_end = 1'b0;
      obs[b] = pix_now();
      if (b == abort_at) de = 1'b1;
    end
  endtask

  // Packet-level expectation for one window; consumes the model's pending state.
  task automatic model_window(input int abort_at);
    int n, st, t, sm;
    bit aborted;
    for (int b = 0; b < MAXW; b++) exp_v[b] = 9'd0;
    n = m_acr + (m_scnt + 3) / 4 + m_avi + m_aif;
    if (n > FIT) n = FIT;
    if (abort_at >= 0 && abort_at < 12) n = 0;
    if (n == 0) return;
    aborted = (abort_at >= 0) && (abort_at <= 23 + 32 * n);
    for (int b = 12; b < 20; b++) exp_v[b] = 9'b1_1_0_0_00_000;
    exp_v[20] = 9'b1_0_1_0_00_000;
    exp_v[21] = 9'b1_0_1_0_00_000;
    for (int k = 0; k < n; k++) begin
      st = 22 + 32 * k;
      if (aborted && st > abort_at) break;
      sm = 0;
      if (m_acr != 0) begin t = 0; m_acr = 0; end
      else if (m_scnt > 0) begin t = 1; sm = (m_scnt > 4) ? 4 : m_scnt; m_scnt -= sm; end
      else if (m_avi != 0) begin t = 2; m_avi = 0; end
      else begin t = 3; m_aif = 0; end
      for (int p = 0; p < 32; p++)
        exp_v[st + p] = {1'b1, 1'b0, 1'b0, (p == 0), 2'(t), 3'(sm)};
    end
    exp_v[22 + 32 * n] = 9'b1_0_1_0_00_000;
    exp_v[23 + 32 * n] = 9'b1_0_1_0_00_000;
    if (aborted) begin
      m_coll = 1'b1;
      for (int b = abort_at + 1; b < MAXW; b++) exp_v[b] = 9'd0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; de = 1'b1; line_end = 1'b0; frame_end = 1'b0;
    audio_sample_strobe = 1'b0; acr_req = 1'b0;
    m_acr = 0; m_scnt = 0; m_avi = 0; m_aif = 0; m_ovf = 1'b0; m_coll = 1'b0;
    repeat (3) tick();
    total++;
    if ({pix_now(), audio_overflow, collision} !== 11'd0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0", {pix_now(), audio_overflow, collision});
    end
    rst = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_basic();
    add_samples(5); pulse_acr();
    capture_window(140, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 140; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL basic_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
  endtask

  task automatic test_no_pending();
    capture_window(360, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 360; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL idle_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
  endtask

  task automatic test_fit_and_vblank();
    pulse_frame(); pulse_acr(); add_samples(31);
    capture_window(360, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 360; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL fit_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    line_end = 1'b1; tick(); line_end = 1'b0;
    repeat (10) tick();
    capture_window(80, -1, 1'b1); model_window(-1);
    total++;
    for (int b = 0; b < 80; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL vblank_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
  endtask

  task automatic test_overflow();
    add_samples(40);
    total++;
    if (audio_overflow !== m_ovf) begin
      bad++; $display("FAIL overflow_set got=%b want=%b", audio_overflow, m_ovf);
    end
    capture_window(300, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 300; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL overflow_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
    total++;
    if (audio_overflow !== m_ovf) begin
      bad++; $display("FAIL overflow_sticky got=%b want=%b", audio_overflow, m_ovf);
    end
  endtask

  task automatic test_abort();
    add_samples(5); pulse_acr();
    capture_window(90, 60, 1'b0); model_window(60);
    total++;
    for (int b = 0; b < 90; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL abort_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    total++;
    if (collision !== m_coll) begin
      bad++; $display("FAIL collision_set got=%b want=%b", collision, m_coll);
    end
    end_line();
    capture_window(100, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 100; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL after_abort_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
    total++;
    if (collision !== m_coll) begin
      bad++; $display("FAIL collision_sticky got=%b want=%b", collision, m_coll);
    end
  endtask

  task automatic test_rst_mid();
    pulse_acr(); add_samples(6);
    de = 1'b0;
    repeat (15) tick();
    total++;
    if (preamble !== 1'b1) begin
      bad++; $display("FAIL preamble_before_rst got=%b want=1", preamble);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({pix_now(), audio_overflow, collision} !== 11'd0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b want=0", {pix_now(), audio_overflow, collision});
    end
    m_acr = 0; m_scnt = 0; m_avi = 0; m_aif = 0; m_ovf = 1'b0; m_coll = 1'b0;
    end_line();
    capture_window(200, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 200; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL post_rst_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
    pulse_acr();
    capture_window(100, -1, 1'b0); model_window(-1);
    total++;
    for (int b = 0; b < 100; b++) if (obs[b] !== exp_v[b]) begin
      bad++; $display("FAIL new_req_window blank=%0d got=%b want=%b", b, obs[b], exp_v[b]); break;
    end
    end_line();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 2) == 0) pulse_acr();
      if ($urandom_range(0, 3) == 0) pulse_frame();
      add_samples(($urandom_range(0, 5) == 0) ? 36 : int'($urandom_range(0, 14)));
      capture_window(360, -1, 1'b0); model_window(-1);
      total++;
      for (int b = 0; b < 360; b++) if (obs[b] !== exp_v[b]) begin
        bad++; $display("FAIL random_window it=%0d blank=%0d got=%b want=%b", it, b, obs[b], exp_v[b]); break;
      end
      end_line();
      total++;
      if ({audio_overflow, collision} !== {m_ovf, m_coll}) begin
        bad++; $display("FAIL random_sticky it=%0d got=%b want=%b", it, {audio_overflow, collision}, {m_ovf, m_coll});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_pending();
    test_fit_and_vblank();
    test_overflow();
    test_abort();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
